// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan controller.
// Shadow registers reload once per frame, so each frame is drawn from one consistent input snapshot.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    output logic [2:0]  num,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       num_q, num_d;
    logic             frame_done_q, frame_done_d;
    logic [31:0]      data_s_q, data_s_d;
    logic [7:0]       dp_s_q, dp_s_d;
    logic [7:0]       en_s_q, en_s_d;
    logic             load_pending_q, load_pending_d;

    logic             step;
    logic             last_digit;
    logic             load;
    logic [3:0]       nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'h40;
            4'h1:    p = 7'h79;
            4'h2:    p = 7'h24;
            4'h3:    p = 7'h30;
            4'h4:    p = 7'h19;
            4'h5:    p = 7'h12;
            4'h6:    p = 7'h02;
            4'h7:    p = 7'h78;
            4'h8:    p = 7'h00;
            4'h9:    p = 7'h10;
            4'hA:    p = 7'h08;
            4'hB:    p = 7'h03;
            4'hC:    p = 7'h46;
            4'hD:    p = 7'h21;
            4'hE:    p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    always_comb begin
        step         = (div_cnt_q == DIV_LAST);
        last_digit   = (num_q == 3'd7);
        // load_pending forces a capture on the first edge out of reset
        load         = (step && last_digit) || load_pending_q;

        div_cnt_d      = step ? '0 : div_cnt_q + CNT_ONE;
        num_d          = step ? num_q + 3'd1 : num_q;
        frame_done_d   = step && last_digit;
        load_pending_d = 1'b0;
        data_s_d       = load ? data     : data_s_q;
        dp_s_d         = load ? dp_in    : dp_s_q;
        en_s_d         = load ? digit_en : en_s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            num_q          <= 3'd0;
            frame_done_q   <= 1'b0;
            data_s_q       <= 32'd0;
            dp_s_q         <= 8'd0;
            en_s_q         <= 8'd0;
            load_pending_q <= 1'b1;
        end else begin
            div_cnt_q      <= div_cnt_d;
            num_q          <= num_d;
            frame_done_q   <= frame_done_d;
            data_s_q       <= data_s_d;
            dp_s_q         <= dp_s_d;
            en_s_q         <= en_s_d;
            load_pending_q <= load_pending_d;
        end
    end

    always_comb begin
        nibble = data_s_q[{num_q, 2'b00} +: 4];
        if (en_s_q[num_q]) seg = {~dp_s_q[num_q], hex7(nibble)};
        else               seg = 8'hFF;
    end

    assign num        = num_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: spec vector tables, hand-written corner sequences,
// and a cycle-count reference model checking two instances (SCAN_DIV 4 and 1) every cycle.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic [2:0]  num4, num1;
    logic [7:0]  seg4, seg1;
    logic        fd4, fd1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(4), .CNT_W(17)) dut4 (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .digit_en(digit_en),
        .num(num4), .seg(seg4), .frame_done(fd4)
    );

    seg7_scan_driver #(.SCAN_DIV(1), .CNT_W(17)) dut1 (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .digit_en(digit_en),
        .num(num1), .seg(seg1), .frame_done(fd1)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [7:0] seg_of(input logic [31:0] d, input logic [7:0] dp,
                                          input logic [7:0] en, input int n);
        logic [31:0] sh;
        if (!en[n]) return 8'hFF;
        sh = d >> (4 * n);
        return {~dp[n], hex_tab[sh[3:0]]};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle count since reset release plus a frame snapshot.
    int          dv  [2] = '{4, 1};
    int          k   [2];
    logic [31:0] md  [2];
    logic [7:0]  mdp [2];
    logic [7:0]  men [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                k[i] = 0; md[i] = '0; mdp[i] = '0; men[i] = '0;
            end else begin
                if (k[i] == 0 || (k[i] % (8 * dv[i])) == 8 * dv[i] - 1) begin
                    md[i] = data; mdp[i] = dp_in; men[i] = digit_en;
                end
                k[i] = k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                int   n_e;
                logic fd_e;
                n_e  = (k[i] / dv[i]) % 8;
                fd_e = (k[i] > 0) && (k[i] % (8 * dv[i]) == 0);
                check(i == 0 ? "model_num_div4" : "model_num_div1",
                      {5'd0, (i == 0 ? num4 : num1)}, 8'(n_e));
                check(i == 0 ? "model_seg_div4" : "model_seg_div1",
                      (i == 0 ? seg4 : seg1), seg_of(md[i], mdp[i], men[i], n_e));
                check(i == 0 ? "model_fd_div4" : "model_fd_div1",
                      {7'd0, (i == 0 ? fd4 : fd1)}, {7'd0, fd_e});
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
        int          digit;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [24];

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("reset_num", {5'd0, num4}, 8'h00);
            check("reset_seg", seg4, 8'hFF);
            check("reset_fd", {7'd0, fd4}, 8'h00);
        end
        rst = 1'b0;
    endtask

    task automatic wait_num4(input logic [2:0] n);
        int c = 0;
        while (num4 !== n && c < 64) begin
            @(negedge clk);
            c++;
        end
        if (num4 !== n) check("wait_num_timeout", {5'd0, num4}, {5'd0, n});
    endtask

    initial begin
        logic [31:0] da, db;
        int cnt;

        vecs[0]  = '{32'h76543210, 8'h00, 8'hFF, 0, 8'hC0};
        vecs[1]  = '{32'h76543210, 8'h00, 8'hFF, 1, 8'hF9};
        vecs[2]  = '{32'h76543210, 8'h00, 8'hFF, 2, 8'hA4};
        vecs[3]  = '{32'h76543210, 8'h00, 8'hFF, 3, 8'hB0};
        vecs[4]  = '{32'h76543210, 8'h00, 8'hFF, 4, 8'h99};
        vecs[5]  = '{32'h76543210, 8'h00, 8'hFF, 5, 8'h92};
        vecs[6]  = '{32'h76543210, 8'h00, 8'hFF, 6, 8'h82};
        vecs[7]  = '{32'h76543210, 8'h00, 8'hFF, 7, 8'hF8};
        vecs[8]  = '{32'hFEDCBA98, 8'h01, 8'hFF, 0, 8'h00};
        vecs[9]  = '{32'hFEDCBA98, 8'h01, 8'hFF, 1, 8'h90};
        vecs[10] = '{32'hFEDCBA98, 8'h01, 8'hFF, 2, 8'h88};
        vecs[11] = '{32'hFEDCBA98, 8'h01, 8'hFF, 3, 8'h83};
        vecs[12] = '{32'hFEDCBA98, 8'h01, 8'hFF, 4, 8'hC6};
        vecs[13] = '{32'hFEDCBA98, 8'h01, 8'hFF, 5, 8'hA1};
        vecs[14] = '{32'hFEDCBA98, 8'h01, 8'hFF, 6, 8'h86};
        vecs[15] = '{32'hFEDCBA98, 8'h01, 8'hFF, 7, 8'h8E};
        vecs[16] = '{32'h76543210, 8'h00, 8'hA5, 0, 8'hC0};
        vecs[17] = '{32'h76543210, 8'h00, 8'hA5, 1, 8'hFF};
        vecs[18] = '{32'h76543210, 8'h00, 8'hA5, 2, 8'hA4};
        vecs[19] = '{32'h76543210, 8'h00, 8'hA5, 3, 8'hFF};
        vecs[20] = '{32'h76543210, 8'h00, 8'hA5, 4, 8'hFF};
        vecs[21] = '{32'h76543210, 8'h00, 8'hA5, 5, 8'h92};
        vecs[22] = '{32'h76543210, 8'h00, 8'hA5, 6, 8'hFF};
        vecs[23] = '{32'h76543210, 8'h00, 8'hA5, 7, 8'hF8};

        rst = 1'b1; data = '0; dp_in = '0; digit_en = '0;
        @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;

        // Table vectors: each group of 8 starts from reset with its inputs applied.
        for (int i = 0; i < 24; i++) begin
            int c;
            if (i % 8 == 0) begin
                data = vecs[i].data; dp_in = vecs[i].dp; digit_en = vecs[i].en;
                do_reset(3);
                @(negedge clk);
            end
            wait_num4(vecs[i].digit[2:0]);
            c = 0;
            while (num4 === vecs[i].digit[2:0] && c < 8) begin
                check("table_seg", seg4, vecs[i].exp);
                @(negedge clk);
                c++;
            end
        end

        // Frame pulse timing and width after a fresh reset.
        data = 32'h76543210; dp_in = 8'h00; digit_en = 8'hFF;
        do_reset(2);
        cnt = 0;
        while (fd4 !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("fd_latency", 8'(cnt), 8'd32);
        check("fd_num_wrap", {5'd0, num4}, 8'h00);
        @(negedge clk);
        check("fd_width", {7'd0, fd4}, 8'h00);

        // Mid-frame data change stays hidden until the wrap.
        da = 32'h76543210; db = 32'h89ABCDEF;
        data = da;
        do_reset(2);
        wait_num4(3'd3);
        data = db;
        wait_num4(3'd4);
        cnt = 0;
        while (num4 !== 3'd0 && cnt < 40) begin
            check("hold_old_frame", seg4, seg_of(da, 8'h00, 8'hFF, int'(num4)));
            @(negedge clk);
            cnt++;
        end
        check("new_frame_digit0", seg4, seg_of(db, 8'h00, 8'hFF, 0));
        wait_num4(3'd1);
        check("new_frame_digit1", seg4, seg_of(db, 8'h00, 8'hFF, 1));

        // Reset while on digit 5, divider phase 2.
        cnt = 0;
        while (!(((k[0] / 4) % 8 == 5) && (k[0] % 4 == 2)) && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check("midscan_reach", 8'(k[0] % 4), 8'd2);
        rst = 1'b1;
        @(negedge clk);
        check("midscan_num", {5'd0, num4}, 8'h00);
        check("midscan_seg", seg4, 8'hFF);
        check("midscan_num_div1", {5'd0, num1}, 8'h00);
        rst = 1'b0;
        cnt = 0;
        while (fd4 !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt <= 8) check("div1_step", {5'd0, num1}, 8'(cnt % 8));
        end
        check("midscan_fd_latency", 8'(cnt), 8'd32);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) data     = $urandom;
            if ($urandom_range(0, 9) == 0) dp_in    = 8'($urandom);
            if ($urandom_range(0, 9) == 0) digit_en = 8'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
